// File: rtl/warp_pc_scheduler.sv
// Per-core instruction-phase sequencer that owns the shared PC for a thread block.
// Divergent lanes are serialised by always issuing at the lowest pending PC.
module warp_pc_scheduler #(
  parameter int unsigned THREADS_PER_BLOCK     = 4,
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]                  thread_count,
  input  logic                                                fetch_done,
  input  logic                                                decoded_ret,
  input  logic [THREADS_PER_BLOCK-1:0]                        lsu_busy,
  input  logic [THREADS_PER_BLOCK*PROGRAM_MEM_ADDR_BITS-1:0]  next_pc,
  output logic [2:0]                                          core_state,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]                    current_pc,
  output logic [THREADS_PER_BLOCK-1:0]                        active_mask,
  output logic                                                done
);

  localparam int unsigned T   = THREADS_PER_BLOCK;
  localparam int unsigned W   = PROGRAM_MEM_ADDR_BITS;
  localparam int unsigned TCW = $clog2(THREADS_PER_BLOCK) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   pc_q, pc_d;
  logic [T-1:0]   mask_q, mask_d;
  logic           done_q, done_d;
  logic [T-1:0]   fin_q, fin_d;
  logic [T-1:0]   en_q, en_d;

  logic [T-1:0]   launch_mask;
  logic [T-1:0]   fin_n;
  logic [T-1:0]   live;
  logic [W-1:0]   min_pc;
  logic [T-1:0]   tie_mask;
  logic [W-1:0]   lane_pc [T];

  // Lanes below thread_count; counts above T naturally enable every lane.
  always_comb begin
    launch_mask = '0;
    for (int i = 0; i < T; i++) begin
      launch_mask[i] = (TCW'(i) < thread_count);
    end
  end

  // Min-PC reconvergence: non-live lanes are gated out so their PCs never matter.
  always_comb begin
    fin_n    = fin_q | (decoded_ret ? mask_q : '0);
    live     = en_q & ~fin_n;
    min_pc   = '1;
    tie_mask = '0;
    for (int i = 0; i < T; i++) begin
      lane_pc[i] = next_pc[i*W +: W];
    end
    for (int i = 0; i < T; i++) begin
      if (live[i] && (lane_pc[i] < min_pc)) min_pc = lane_pc[i];
    end
    for (int i = 0; i < T; i++) begin
      tie_mask[i] = live[i] && (lane_pc[i] == min_pc);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mask_d  = mask_q;
    done_d  = done_q;
    fin_d   = fin_q;
    en_d    = en_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          fin_d  = '0;
          en_d   = launch_mask;
          pc_d   = '0;
          mask_d = launch_mask;
          if (launch_mask == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH:   if (fetch_done) state_d = S_DECODE;
      S_DECODE:  state_d = S_REQUEST;
      S_REQUEST: state_d = S_WAIT;
      S_WAIT:    if ((lsu_busy & mask_q) == '0) state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_UPDATE;
      S_UPDATE: begin
        fin_d = fin_n;
        if (live == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          mask_d  = '0;
        end else begin
          state_d = S_FETCH;
          pc_d    = min_pc;
          mask_d  = tie_mask;
        end
      end
      S_DONE:    state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
      fin_q   <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      fin_q   <= fin_d;
      en_q    <= en_d;
    end
  end

  assign core_state  = state_q;
  assign current_pc  = pc_q;
  assign active_mask = mask_q;
  assign done        = done_q;

endmodule
